// File: rtl/key_expand_param.sv
// key_expand_param: AES key schedule for 128/192/256-bit keys.
//
// Loads the cipher key one 32-bit word per accepted key_valid beat, expands it
// one word per cycle into an NW x 32 register file, then serves any round-key
// word combinationally.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   start          single-cycle request to load a new key (IDLE/DONE only)
//   key_valid      qualifies cipher_key while loading
//   cipher_key     key word, most significant word first
//   round_key_num  round key select, 0..NR
//   r_index        word within the round key (0 = most significant)
//   dec_sel        inverse-cipher round keys (only with KEY_EXPAND_DEC_EN)
//   round_key      selected round-key word, 0 unless done and in range
//   busy           high while loading or expanding
//   done           high while the full schedule is valid
//
// Build option: define KEY_EXPAND_DEC_EN to add the dec_sel port and the
// InvMixColumns read path used by the equivalent inverse cipher.
module key_expand_param #(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        key_valid,
    input  logic [31:0] cipher_key,
    input  logic [3:0]  round_key_num,
    input  logic [1:0]  r_index,
`ifdef KEY_EXPAND_DEC_EN
    input  logic        dec_sel,
`endif
    output logic [31:0] round_key,
    output logic        busy,
    output logic        done
);

    localparam int unsigned NK = KEY_BITS / 32;
    localparam int unsigned NR = NK + 6;
    localparam int unsigned NW = 4 * (NR + 1);

    localparam logic [5:0] NK_W      = 6'(NK);
    localparam logic [5:0] LAST_LOAD = 6'(NK - 1);
    localparam logic [5:0] LAST_WORD = 6'(NW - 1);
    localparam logic [3:0] NR_W      = 4'(NR);
    localparam logic [2:0] SUB_LAST  = 3'(NK - 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("key_expand_param: KEY_BITS must be 128, 192 or 256");
    end

    // ------------------------------------------------------------------
    // GF(2^8) helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as multiplicative inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 0; k < 7; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

`ifdef KEY_EXPAND_DEC_EN
    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {gf_mul(b0, 8'h0e) ^ gf_mul(b1, 8'h0b) ^ gf_mul(b2, 8'h0d) ^ gf_mul(b3, 8'h09),
                gf_mul(b0, 8'h09) ^ gf_mul(b1, 8'h0e) ^ gf_mul(b2, 8'h0b) ^ gf_mul(b3, 8'h0d),
                gf_mul(b0, 8'h0d) ^ gf_mul(b1, 8'h09) ^ gf_mul(b2, 8'h0e) ^ gf_mul(b3, 8'h0b),
                gf_mul(b0, 8'h0b) ^ gf_mul(b1, 8'h0d) ^ gf_mul(b2, 8'h09) ^ gf_mul(b3, 8'h0e)};
    endfunction
`endif

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {StIdle, StLoad, StExpand, StDone} state_e;

    state_e     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;     // next word index to write
    logic [2:0] sub_q, sub_d;     // cnt mod NK, avoids a divider for NK=6
    logic [7:0] rcon_q, rcon_d;

    logic [31:0] w_q [NW];
    logic        w_we;
    logic [31:0] w_din;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 6'd0;
            sub_q   <= 3'd0;
            rcon_q  <= 8'h01;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            rcon_q  <= rcon_d;
        end
    end

    // Key storage is intentionally unreset; done gates every read.
    always_ff @(posedge clk) begin
        if (w_we) w_q[cnt_q] <= w_din;
    end

    // ------------------------------------------------------------------
    // Expansion datapath: one SubWord (four S-boxes) shared by both cases
    // ------------------------------------------------------------------
    logic [31:0] w_prev;
    logic [31:0] w_far;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] t_word;

    always_comb begin
        w_prev  = w_q[cnt_q - 6'd1];
        w_far   = w_q[cnt_q - NK_W];
        sub_in  = (sub_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                   sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
        if (sub_q == 3'd0) begin
            t_word = sub_out ^ {rcon_q, 24'h0};
        end else if (NK == 8 && sub_q == 3'd4) begin
            t_word = sub_out;
        end else begin
            t_word = w_prev;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        rcon_d  = rcon_q;
        w_we    = 1'b0;
        w_din   = cipher_key;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StLoad;
                    cnt_d   = 6'd0;
                    sub_d   = 3'd0;
                    rcon_d  = 8'h01;
                end
            end
            StLoad: begin
                if (key_valid) begin
                    w_we  = 1'b1;
                    w_din = cipher_key;
                    cnt_d = cnt_q + 6'd1;
                    sub_d = (sub_q == SUB_LAST) ? 3'd0 : sub_q + 3'd1;
                    if (cnt_q == LAST_LOAD) state_d = StExpand;
                end
            end
            StExpand: begin
                w_we  = 1'b1;
                w_din = w_far ^ t_word;
                cnt_d = cnt_q + 6'd1;
                sub_d = (sub_q == SUB_LAST) ? 3'd0 : sub_q + 3'd1;
                if (sub_q == 3'd0) rcon_d = xtime(rcon_q);
                if (cnt_q == LAST_WORD) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [5:0]  rd_idx;
    logic [31:0] rd_word;

    always_comb begin
        busy    = (state_q == StLoad) || (state_q == StExpand);
        done    = (state_q == StDone);
        rd_idx  = {round_key_num, r_index};
        rd_word = w_q[rd_idx];
        round_key = 32'h0;
        if (done && round_key_num <= NR_W) begin
            round_key = rd_word;
`ifdef KEY_EXPAND_DEC_EN
            // First and last round keys are used unmixed by the inverse cipher.
            if (dec_sel && round_key_num != 4'd0 && round_key_num != NR_W) begin
                round_key = inv_mix_col(rd_word);
            end
`endif
        end
    end

endmodule

// File: tb/tb_key_expand_param.sv
module tb_key_expand_param;

    typedef logic [31:0] key_t [8];

    typedef struct {
        int          k;
        logic [3:0]  rkn;
        logic [1:0]  ri;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start      [3];
    logic        key_valid  [3];
    logic [31:0] cipher_key [3];
    logic [3:0]  rkn        [3];
    logic [1:0]  ri         [3];
`ifdef KEY_EXPAND_DEC_EN
    logic        dec_sel    [3];
`endif
    logic [31:0] round_key  [3];
    logic        busy       [3];
    logic        done       [3];

    int checks = 0;
    int errors = 0;

    key_t key128, key192, key256, key_zero;
    vec_t vecs[$];

    always #5 clk = ~clk;

    key_expand_param #(.KEY_BITS(128)) u128 (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .key_valid(key_valid[0]),
        .cipher_key(cipher_key[0]), .round_key_num(rkn[0]), .r_index(ri[0]),
`ifdef KEY_EXPAND_DEC_EN
        .dec_sel(dec_sel[0]),
`endif
        .round_key(round_key[0]), .busy(busy[0]), .done(done[0]));

    key_expand_param #(.KEY_BITS(192)) u192 (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .key_valid(key_valid[1]),
        .cipher_key(cipher_key[1]), .round_key_num(rkn[1]), .r_index(ri[1]),
`ifdef KEY_EXPAND_DEC_EN
        .dec_sel(dec_sel[1]),
`endif
        .round_key(round_key[1]), .busy(busy[1]), .done(done[1]));

    key_expand_param #(.KEY_BITS(256)) u256 (
        .clk(clk), .reset_n(reset_n), .start(start[2]), .key_valid(key_valid[2]),
        .cipher_key(cipher_key[2]), .round_key_num(rkn[2]), .r_index(ri[2]),
`ifdef KEY_EXPAND_DEC_EN
        .dec_sel(dec_sel[2]),
`endif
        .round_key(round_key[2]), .busy(busy[2]), .done(done[2]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_chk(input int k, input logic [3:0] r, input logic [1:0] i,
                            input logic [31:0] exp, input string name);
        rkn[k] = r;
        ri[k]  = i;
        #1;
        chk(name, round_key[k], exp);
    endtask

    // Pulses start, feeds nk words (optionally with a one-cycle gap before each),
    // then waits for done; mid_start >= 0 pulses start at that cycle of the wait.
    task automatic load_key(input int k, input key_t key, input int nk, input bit gap,
                            input int mid_start, input int exp_cyc, input string name);
        int cyc;
        start[k] = 1'b1;
        step();
        start[k] = 1'b0;
        chk({name, " busy_in_load"}, {31'b0, busy[k]}, 32'd1);
        chk({name, " done_fell"}, {31'b0, done[k]}, 32'd0);
        cyc = 0;
        for (int j = 0; j < nk; j++) begin
            if (gap) begin
                key_valid[k] = 1'b0;
                step();
                cyc++;
            end
            key_valid[k]  = 1'b1;
            cipher_key[k] = key[j];
            step();
            cyc++;
        end
        key_valid[k]  = 1'b0;
        cipher_key[k] = 32'hdeadbeef;
        while (!done[k] && cyc < 300) begin
            start[k] = (cyc == mid_start);
            step();
            cyc++;
        end
        start[k] = 1'b0;
        chk({name, " cycles_to_done"}, 32'(cyc), 32'(exp_cyc));
        chk({name, " busy_at_done"}, {31'b0, busy[k]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        key128   = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c,
                     32'h0, 32'h0, 32'h0, 32'h0};
        key192   = '{32'h8e73b0f7, 32'hda0e6452, 32'hc810f32b, 32'h809079e5,
                     32'h62f8ead2, 32'h522c6b7b, 32'h0, 32'h0};
        key256   = '{32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
                     32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4};
        key_zero = '{default: 32'h0};

        // AES-128 FIPS-197 key
        vecs.push_back('{0, 4'd0,  2'd0, 32'h2b7e1516});
        vecs.push_back('{0, 4'd0,  2'd3, 32'h09cf4f3c});
        vecs.push_back('{0, 4'd1,  2'd0, 32'ha0fafe17});
        vecs.push_back('{0, 4'd1,  2'd1, 32'h88542cb1});
        vecs.push_back('{0, 4'd1,  2'd2, 32'h23a33939});
        vecs.push_back('{0, 4'd1,  2'd3, 32'h2a6c7605});
        vecs.push_back('{0, 4'd10, 2'd0, 32'hd014f9a8});
        vecs.push_back('{0, 4'd10, 2'd1, 32'hc9ee2589});
        vecs.push_back('{0, 4'd10, 2'd2, 32'he13f0cc8});
        vecs.push_back('{0, 4'd10, 2'd3, 32'hb6630ca6});
        vecs.push_back('{0, 4'd11, 2'd0, 32'h0});
        vecs.push_back('{0, 4'd15, 2'd3, 32'h0});
        // AES-192
        vecs.push_back('{1, 4'd0,  2'd0, 32'h8e73b0f7});
        vecs.push_back('{1, 4'd1,  2'd0, 32'h62f8ead2});
        vecs.push_back('{1, 4'd1,  2'd1, 32'h522c6b7b});
        vecs.push_back('{1, 4'd1,  2'd2, 32'hfe0c91f7});
        vecs.push_back('{1, 4'd1,  2'd3, 32'h2402f5a5});
        vecs.push_back('{1, 4'd12, 2'd0, 32'he98ba06f});
        vecs.push_back('{1, 4'd12, 2'd1, 32'h448c773c});
        vecs.push_back('{1, 4'd12, 2'd2, 32'h8ecc7204});
        vecs.push_back('{1, 4'd12, 2'd3, 32'h01002202});
        vecs.push_back('{1, 4'd13, 2'd0, 32'h0});
        // AES-256
        vecs.push_back('{2, 4'd1,  2'd3, 32'h0914dff4});
        vecs.push_back('{2, 4'd2,  2'd0, 32'h9ba35411});
        vecs.push_back('{2, 4'd2,  2'd1, 32'h8e6925af});
        vecs.push_back('{2, 4'd2,  2'd2, 32'ha51a8b5f});
        vecs.push_back('{2, 4'd2,  2'd3, 32'h2067fcde});
        vecs.push_back('{2, 4'd3,  2'd0, 32'ha8b09c1a});
        vecs.push_back('{2, 4'd14, 2'd0, 32'hfe4890d1});
        vecs.push_back('{2, 4'd14, 2'd1, 32'he6188d0b});
        vecs.push_back('{2, 4'd14, 2'd2, 32'h046df344});
        vecs.push_back('{2, 4'd14, 2'd3, 32'h706c631e});
        vecs.push_back('{2, 4'd15, 2'd0, 32'h0});

        for (int k = 0; k < 3; k++) begin
            start[k]      = 1'b0;
            key_valid[k]  = 1'b0;
            cipher_key[k] = 32'h0;
            rkn[k]        = 4'd0;
            ri[k]         = 2'd0;
`ifdef KEY_EXPAND_DEC_EN
            dec_sel[k]    = 1'b0;
`endif
        end

        // Reset state
        reset_n = 1'b0;
        repeat (3) step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset busy u%0d", k), {31'b0, busy[k]}, 32'd0);
            chk($sformatf("reset done u%0d", k), {31'b0, done[k]}, 32'd0);
        end
        read_chk(0, 4'd0, 2'd0, 32'h0, "reset round_key");
        reset_n = 1'b1;

        // Start on the first edge after release
        load_key(0, key128, 4, 1'b0, -1, 44, "aes128");
        load_key(1, key192, 6, 1'b0, -1, 52, "aes192");
        load_key(2, key256, 8, 1'b1, -1, 68, "aes256_gapped");

        foreach (vecs[n]) begin
            read_chk(vecs[n].k, vecs[n].rkn, vecs[n].ri, vecs[n].exp,
                     $sformatf("vec%0d u%0d rk%0d w%0d", n, vecs[n].k, vecs[n].rkn, vecs[n].ri));
        end

        // All-zero key on the 128-bit instance, reloaded from DONE
        load_key(0, key_zero, 4, 1'b0, -1, 44, "zero_key");
        for (int i = 0; i < 4; i++) begin
            read_chk(0, 4'd1, 2'(i), 32'h62636363, $sformatf("zero rk1 w%0d", i));
        end
        read_chk(0, 4'd10, 2'd0, 32'hb4ef5bcb, "zero rk10 w0");
        read_chk(0, 4'd10, 2'd3, 32'h6f8f188e, "zero rk10 w3");
`ifdef KEY_EXPAND_DEC_EN
        dec_sel[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            read_chk(0, 4'd1, 2'(i), 32'h6d6a6e68, $sformatf("dec rk1 w%0d", i));
        end
        read_chk(0, 4'd10, 2'd0, 32'hb4ef5bcb, "dec rk10 unchanged");
        read_chk(0, 4'd0,  2'd0, 32'h0, "dec rk0 unchanged");
        dec_sel[0] = 1'b0;
`endif

        // start pulsed mid-EXPAND is ignored
        load_key(0, key128, 4, 1'b0, 24, 44, "mid_start");
        read_chk(0, 4'd10, 2'd0, 32'hd014f9a8, "mid_start rk10 w0");
        read_chk(0, 4'd10, 2'd3, 32'hb6630ca6, "mid_start rk10 w3");

        // Reset pulsed at EXPAND cycle 20
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            key_valid[0]  = 1'b1;
            cipher_key[0] = key_zero[j];
            step();
        end
        key_valid[0] = 1'b0;
        repeat (20) step();
        chk("abort busy_before", {31'b0, busy[0]}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort busy_async", {31'b0, busy[0]}, 32'd0);
        chk("abort done_async", {31'b0, done[0]}, 32'd0);
        read_chk(0, 4'd10, 2'd0, 32'h0, "abort round_key_async");
        step();
        reset_n = 1'b1;
        repeat (5) step();
        chk("after_abort done", {31'b0, done[0]}, 32'd0);
        chk("after_abort busy", {31'b0, busy[0]}, 32'd0);
        read_chk(0, 4'd10, 2'd0, 32'h0, "after_abort round_key");
        load_key(0, key128, 4, 1'b0, -1, 44, "reload");
        read_chk(0, 4'd10, 2'd1, 32'hc9ee2589, "reload rk10 w1");
        read_chk(0, 4'd10, 2'd2, 32'he13f0cc8, "reload rk10 w2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_expand_param.md
KEY_EXPAND_PARAM -- requirements
Module: key_expand_param

Interface
REQ-001 SHALL have parameter KEY_BITS, default 128: cipher key length; legal values 128, 192, 256; any other value SHALL cause an elaboration error.
REQ-002 SHALL derive localparams NK = KEY_BITS/32 (4/6/8), NR = NK+6 (10/12/14) and NW = 4*(NR+1) (44/52/60 words).
REQ-003 clk  input  1  rising-edge clock; the block's only clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin loading a new key.
REQ-006 key_valid  input  1  qualifies cipher_key during load.
REQ-007 cipher_key  input  32  key word; NK words, most significant word first.
REQ-008 round_key_num  input  4  round key select, 0..NR.
REQ-009 r_index  input  2  word select within the round key; 0 = w[4r] (key bits 127:96), 3 = w[4r+3].
REQ-010 dec_sel  input  1  selects inverse-cipher round keys (present only under REQ-031).
REQ-011 round_key  output  32  selected round-key word.
REQ-012 busy  output  1  high in LOAD and EXPAND.
REQ-013 done  output  1  high while the full schedule is valid.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, EXPAND, DONE.
REQ-015 IDLE or DONE with start=1 -> LOAD next cycle; word counter cleared; done falls the same edge.
REQ-016 start in LOAD or EXPAND SHALL be ignored; key_valid outside LOAD SHALL be ignored.
REQ-017 LOAD: each cycle with key_valid=1 SHALL write cipher_key to w[cnt] and increment cnt; gaps (key_valid=0) SHALL stall without penalty.
REQ-018 On the edge writing w[NK-1], SHALL go to EXPAND with i=NK.
REQ-019 EXPAND SHALL write exactly one word per cycle: w[i] = w[i-NK] ^ t, where t = SubWord(RotWord(w[i-1])) ^ {Rcon[i/NK],24'h0} if i mod NK = 0; SubWord(w[i-1]) if NK=8 and i mod NK = 4; otherwise w[i-1].
REQ-020 Rcon SHALL be generated by GF(2^8) xtime from 8'h01: 01,02,04,08,10,20,40,80,1b,36; no table beyond 10 entries.
REQ-021 After writing w[NW-1], SHALL go to DONE; done SHALL be high from the next cycle. EXPAND lasts NW-NK cycles (40/46/52).
REQ-022 The S-box SHALL be combinational (4 instances); no pipelining of the S-box is permitted.
REQ-023 round_key SHALL be combinational from storage: w[4*round_key_num + r_index].
REQ-024 round_key SHALL be 32'h0 when done=0 or round_key_num > NR.
REQ-025 Word counter SHALL be 6 bits; it SHALL NOT wrap because EXPAND terminates at NW-1.
REQ-026 Key storage SHALL be NW x 32 registers, unreset.

Reset
REQ-027 reset_n=0 SHALL asynchronously force IDLE, cnt=0, Rcon=8'h01, busy=0, done=0, round_key=0.
REQ-028 Reset asserted mid-LOAD or mid-EXPAND SHALL abort; after release, done SHALL stay 0 until a complete new start/load/expand sequence finishes.
REQ-029 First start SHALL be accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-030 Macro KEY_EXPAND_DEC_EN SHALL control equivalent-inverse-cipher support.
REQ-031 When defined: dec_sel port exists; with dec_sel=1 and 1 <= round_key_num <= NR-1, round_key SHALL equal InvMixColumns(selected word), applied combinationally on read; rounds 0 and NR SHALL be unchanged.
REQ-032 When undefined: no dec_sel port and no InvMixColumns logic; encryption keys only.

Verification
REQ-033 KEY_BITS=128, key 2b7e1516 28aed2a6 abf71588 09cf4f3c -> done after 4 load + 40 expand cycles; round 10, r_index 0..3 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
REQ-034 KEY_BITS=192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> round 12 = e98ba06f 448c773c 8ecc7204 01002202; round_key_num=13 -> 0.
REQ-035 KEY_BITS=256, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4, key_valid gapped every other cycle -> round 14 = fe4890d1 e6188d0b 046df344 706c631e.
REQ-036 KEY_BITS=128: start mid-EXPAND -> ignored, done rises on schedule; reset_n pulsed at EXPAND cycle 20 -> done=0, round_key=0 until a reload completes.
REQ-037 With KEY_EXPAND_DEC_EN, KEY_BITS=128, all-zero key: dec_sel=0, round 1 -> 62636363 for all r_index; dec_sel=1 -> 6d6a6e68; round 10 unchanged by dec_sel.
